switch_input_unit: RTL
======================

// Module: switch_input_unit
// PURPOSE
//  Input-side counterpart of the LED output register: brings the board switch bank into the
//  datapath as a clean, debounced, handshaked snapshot. The CPU's memory-mapped I/O logic
//  reads SW_DATA when SW_READY is set, pulses RD_SW to consume the snapshot, and checks
//  SW_OVERRUN for lost updates.
// PARAMETERS
//  WIDTH            16      switch bank width, bits
//  DEBOUNCE_CYCLES  50000   stable cycles required before commit (1 ms @ 50 MHz); must be >= 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, do not override)
// PORTS
//  Clk          in   1      system clock; all state updates on rising edge
//  Reset        in   1      synchronous, active-high reset
//  SW           in   WIDTH  raw switch levels, asynchronous to Clk
//  RD_SW        in   1      1-cycle read strobe from CPU I/O decode; consumes the current snapshot
//  SW_DATA      out  WIDTH  last committed debounced switch value (registered)
//  SW_READY     out  1      set when a new value commits; cleared by RD_SW
//  SW_OVERRUN   out  1      sticky: a commit occurred while SW_READY was still set
// BEHAVIOUR
//  - Reset (sync, active-high): SW_DATA=0, SW_READY=0, SW_OVERRUN=0, both sync flops=0,
//    cand=0, cnt=0, state=STABLE. Reset asserted mid-settle aborts the settle; no commit.
//    After release, any nonzero SW is debounced and committed normally (SW_READY=1).
//  - Synchroniser: 2 flops, sw_q1<=SW, sw_s<=sw_q1. Only sw_s feeds the FSM.
//  - FSM, 2 states:
//    STABLE:   sw_s!=SW_DATA -> SETTLING, cand<=sw_s, cnt<=0. Otherwise hold.
//    SETTLING, evaluated in priority order:
//      1. sw_s==SW_DATA             -> STABLE, no commit (bounce returned to old value)
//      2. sw_s!=cand                -> cand<=sw_s, cnt<=0, stay
//      3. cnt==DEBOUNCE_CYCLES-1    -> commit: SW_DATA<=cand, go STABLE, cnt<=0
//      4. otherwise                 -> cnt<=cnt+1
//  - Latency: SW change first sampled on edge E -> SW_DATA and SW_READY valid after edge
//    E+DEBOUNCE_CYCLES+2. No intermediate value ever appears on SW_DATA.
//  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//  - Handshake, evaluated per edge:
//    commit & !RD_SW             : SW_READY<=1; SW_OVERRUN<=1 if SW_READY was already 1
//    commit &  RD_SW             : SW_READY<=1, SW_OVERRUN<=0 (read consumed the old value)
//    !commit & RD_SW             : SW_READY<=0, SW_OVERRUN<=0
//    RD_SW with SW_READY=0       : harmless; clears SW_OVERRUN, SW_DATA unchanged
//  - SW_DATA holds between commits regardless of RD_SW; reads are non-destructive to data.
// CONFIGURATION
//  SWITCH_DEBOUNCE_EN defined (board build): FSM and counter as above.
//  Undefined (fast simulation): no counter, no FSM. Commit whenever sw_s!=SW_DATA:
//    SW_DATA<=sw_s on that edge. Latency E+2. Handshake/overrun rules are unchanged.
//    Parameter DEBOUNCE_CYCLES is accepted but ignored.
// TESTING  (DEBOUNCE_CYCLES=4, SWITCH_DEBOUNCE_EN defined unless noted)
//  1. Reset 2 cycles with SW=16'hFFFF -> SW_DATA=0, SW_READY=0, SW_OVERRUN=0 while Reset=1;
//     after release, SW_DATA=16'hFFFF, SW_READY=1 at E+6.
//  2. SW 0->16'h1234, held -> SW_DATA=16'h1234, SW_READY=1 exactly at E+6; then RD_SW pulse
//     -> SW_READY=0 next cycle, SW_DATA stays 16'h1234.
//  3. SW toggles 16'h0001/16'h0000 every 2 cycles for 20 cycles, then holds 16'h0001
//     -> exactly one commit of 16'h0001; SW_DATA never shows any other value.
//  4. SW_DATA=16'h1234; SW=16'h00FF for 2 cycles, then back to 16'h1234
//     -> no commit, SW_READY stays 0, SW_DATA=16'h1234.
//  5. Commit 16'hAAAA, no read, then commit 16'h5555 -> SW_OVERRUN=1, SW_DATA=16'h5555;
//     RD_SW -> SW_READY=0, SW_OVERRUN=0. Repeat with RD_SW on the second commit edge
//     -> SW_READY=1, SW_OVERRUN=0.
//  6. SWITCH_DEBOUNCE_EN undefined: SW 0->16'h0F0F -> SW_DATA=16'h0F0F, SW_READY=1 at E+2.

Source files
------------

// File: rtl/switch_input_unit.sv
`default_nettype none
// ============================================================================
// switch_input_unit: synchronised, debounced, handshaked switch-bank snapshot.
// Define SWITCH_DEBOUNCE_EN for the debounce FSM; otherwise commits on change.
// Rev 1.0
// ============================================================================
module switch_input_unit #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             RD_SW,
  output logic [WIDTH-1:0] SW_DATA,
  output logic             SW_READY,
  output logic             SW_OVERRUN
);

  if (DEBOUNCE_CYCLES < 2 || CNT_W < 1) begin : g_param_check
    $error("switch_input_unit: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] sw_q1_q;
  logic [WIDTH-1:0] sw_s_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             commit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_q1_q <= '0;
      sw_s_q  <= '0;
    end else begin
      sw_q1_q <= SW;
      sw_s_q  <= sw_q1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_STABLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    data_d  = data_q;
    case (state_q)
      ST_STABLE: begin
        if (sw_s_q != data_q) begin
          state_d = ST_SETTLING;
          cand_d  = sw_s_q;
          cnt_d   = '0;
        end
      end
      ST_SETTLING: begin
        // A bounce back to the committed value abandons the settle silently.
        if (sw_s_q == data_q) begin
          state_d = ST_STABLE;
        end else if (sw_s_q != cand_q) begin
          cand_d = sw_s_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          data_d  = cand_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end
`else
  always_comb begin
    commit = (sw_s_q != data_q);
    data_d = commit ? sw_s_q : data_q;
  end
`endif

  always_comb begin
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (commit) begin
      ready_d = 1'b1;
    end else if (RD_SW) begin
      ready_d = 1'b0;
    end
    // A read in the same edge as a commit consumed the old value, so no overrun.
    if (RD_SW) begin
      overrun_d = 1'b0;
    end else if (commit && ready_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign SW_DATA    = data_q;
  assign SW_READY   = ready_q;
  assign SW_OVERRUN = overrun_q;

endmodule
`default_nettype wire
